// File: rtl/cp0_pkg.sv
// cp0_pkg: shared definitions for the CP0 exception/interrupt controller.
//   - CP0 register numbers (rd field of mfc0/mtc0)
//   - Status / Cause bit positions
//   - ExcCode encodings and the exception priority encoder
package cp0_pkg;

  // CP0 register numbers
  localparam logic [4:0] CP0_ADDR_COUNT   = 5'd9;
  localparam logic [4:0] CP0_ADDR_COMPARE = 5'd11;
  localparam logic [4:0] CP0_ADDR_STATUS  = 5'd12;
  localparam logic [4:0] CP0_ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_ADDR_EPC     = 5'd14;
  localparam logic [4:0] CP0_ADDR_PRID    = 5'd15;

  // Status bit positions
  localparam int STATUS_IE_BIT = 0;
  localparam int STATUS_EXL_BIT = 1;
  localparam int STATUS_IM_LO = 8;

  // Cause bit positions
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO = 8;

  // Exception codes
  typedef enum logic [4:0] {
    EXC_INT = 5'd0,
    EXC_SYS = 5'd8,
    EXC_RI  = 5'd10,
    EXC_OV  = 5'd12
  } exc_code_e;

  // Priority encoder: RI > Ov > Sys > Int. Int is the fall-through because
  // the code is only latched when at least one source is active.
  function automatic exc_code_e exc_code_sel(input logic ri, input logic ov, input logic sys);
    exc_code_e code;
    if (ri) begin
      code = EXC_RI;
    end else if (ov) begin
      code = EXC_OV;
    end else if (sys) begin
      code = EXC_SYS;
    end else begin
      code = EXC_INT;
    end
    return code;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: CP0 Count/Compare timer with a sticky pending flag.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   wr_count         : committed mtc0 to Count (load instead of increment)
//   wr_compare       : committed mtc0 to Compare (also clears pending)
//   wdata            : mtc0 write data
//   count, compare   : current register values
//   pending          : sticky timer interrupt request (feeds IP[7])
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_count,
  input  logic        wr_compare,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        pending
);

  logic [31:0] count_inc_s;

  // Next free-running count value; wraps naturally at 32 bits.
  always_comb begin
    count_inc_s = count + 32'd1;
  end

  // Count/Compare registers and sticky pending flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= 32'h0000_0000;
      compare <= 32'hFFFF_FFFF;
      pending <= 1'b0;
    end else begin
      if (wr_count) begin
        count <= wdata;
      end else begin
        count <= count_inc_s;
      end

      // A Compare write clears pending even if a match happens this cycle.
      if (wr_compare) begin
        compare <= wdata;
        pending <= 1'b0;
      end else if (!wr_count && (count_inc_s == compare)) begin
        compare <= compare;
        pending <= 1'b1;
      end else begin
        compare <= compare;
        pending <= pending;
      end
    end
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: Coprocessor-0 exception/interrupt controller for the
// single-cycle MIPS core. Holds Status, Cause and EPC, prioritises
// synchronous exceptions over masked interrupts and serves mfc0/mtc0.
// Optional feature: define CP0_TIMER_EN to add the Count/Compare timer
// (cp0_timer); without it Count/Compare read as 0 and IP[7] = Irq[5].
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   Irq[5:0]    : level-sensitive hardware interrupts -> IP[7:2]
//   PresentPC   : PC of the current instruction (saved into EPC)
//   IsEret, Mtc0, Syscall, RiExc, OvExc : current-instruction decode
//   Cp0Addr, Cp0WData : CP0 register number and mtc0 data
//   HasExp      : exception taken this cycle (combinational)
//   EPC         : EPC register for eret
//   Cp0RData    : combinational mfc0 read data
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  Irq,
  input  logic [31:0] PresentPC,
  input  logic        IsEret,
  input  logic        Mtc0,
  input  logic [4:0]  Cp0Addr,
  input  logic [31:0] Cp0WData,
  input  logic        Syscall,
  input  logic        RiExc,
  input  logic        OvExc,
  output logic        HasExp,
  output logic [31:0] EPC,
  output logic [31:0] Cp0RData
);

  // Architectural state
  logic [7:0]  im_r;
  logic        exl_r;
  logic        ie_r;
  logic [5:0]  ip_hw_r;
  logic [1:0]  ip_sw_r;
  logic [4:0]  exc_code_r;
  logic [31:0] epc_r;

  // Derived signals
  logic [7:0]  ip_s;
  logic        int_pending_s;
  logic        has_exp_s;
  exc_code_e   win_code_s;
  logic        wr_commit_s;
  logic [31:0] count_s;
  logic [31:0] compare_s;
  logic        timer_pending_s;

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_count   (wr_commit_s && (Cp0Addr == CP0_ADDR_COUNT)),
    .wr_compare (wr_commit_s && (Cp0Addr == CP0_ADDR_COMPARE)),
    .wdata      (Cp0WData),
    .count      (count_s),
    .compare    (compare_s),
    .pending    (timer_pending_s)
  );
`else
  assign count_s         = 32'h0000_0000;
  assign compare_s       = 32'h0000_0000;
  assign timer_pending_s = 1'b0;
`endif

  // Exception detection and priority; zero-latency from state and inputs.
  always_comb begin
    ip_s          = {ip_hw_r[5] | timer_pending_s, ip_hw_r[4:0], ip_sw_r};
    int_pending_s = ie_r & ~exl_r & (|(ip_s & im_r));
    has_exp_s     = RiExc | OvExc | Syscall | int_pending_s;
    win_code_s    = exc_code_sel(RiExc, OvExc, Syscall);
    // A faulting or interrupted instruction never commits its mtc0.
    wr_commit_s   = Mtc0 & ~has_exp_s;
  end

  assign HasExp = has_exp_s;
  assign EPC    = epc_r;

  // Status/Cause/EPC update: exception entry, eret and mtc0 writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      im_r       <= 8'h00;
      exl_r      <= 1'b0;
      ie_r       <= 1'b0;
      ip_hw_r    <= 6'h00;
      ip_sw_r    <= 2'b00;
      exc_code_r <= 5'd0;
      epc_r      <= 32'h0000_0000;
    end else begin
      ip_hw_r <= Irq;
      if (has_exp_s) begin
        exc_code_r <= win_code_s;
        // Nested exceptions inside a handler keep the original return PC.
        if (!exl_r) begin
          epc_r <= PresentPC;
          exl_r <= 1'b1;
        end else begin
          epc_r <= epc_r;
          exl_r <= exl_r;
        end
      end else begin
        if (IsEret) begin
          exl_r <= 1'b0;
        end else if (wr_commit_s && (Cp0Addr == CP0_ADDR_STATUS)) begin
          exl_r <= Cp0WData[STATUS_EXL_BIT];
        end else begin
          exl_r <= exl_r;
        end

        if (wr_commit_s) begin
          case (Cp0Addr)
            CP0_ADDR_STATUS: begin
              im_r <= Cp0WData[STATUS_IM_LO +: 8];
              ie_r <= Cp0WData[STATUS_IE_BIT];
            end
            CP0_ADDR_CAUSE: begin
              ip_sw_r <= Cp0WData[CAUSE_IP_LO +: 2];
            end
            CP0_ADDR_EPC: begin
              epc_r <= Cp0WData;
            end
            default: begin
              // Count/Compare live in the timer; others are read-only.
            end
          endcase
        end else begin
          epc_r <= epc_r;
        end
      end
    end
  end

  // mfc0 read multiplexer.
  always_comb begin
    Cp0RData = 32'h0000_0000;
    case (Cp0Addr)
      CP0_ADDR_COUNT:   Cp0RData = count_s;
      CP0_ADDR_COMPARE: Cp0RData = compare_s;
      CP0_ADDR_STATUS: begin
        Cp0RData[STATUS_IM_LO +: 8] = im_r;
        Cp0RData[STATUS_EXL_BIT]    = exl_r;
        Cp0RData[STATUS_IE_BIT]     = ie_r;
      end
      CP0_ADDR_CAUSE: begin
        Cp0RData[CAUSE_IP_LO +: 8]  = ip_s;
        Cp0RData[CAUSE_EXC_LO +: 5] = exc_code_r;
      end
      CP0_ADDR_EPC:     Cp0RData = epc_r;
      CP0_ADDR_PRID:    Cp0RData = PRID_VALUE;
      default:          Cp0RData = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scoreboard bench for cp0_exc_ctrl: the driver applies one instruction per
// cycle and queues the expected outputs for that cycle; the monitor pops and
// compares them on the falling edge.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  Irq;
  logic [31:0] PresentPC;
  logic        IsEret;
  logic        Mtc0;
  logic [4:0]  Cp0Addr;
  logic [31:0] Cp0WData;
  logic        Syscall;
  logic        RiExc;
  logic        OvExc;
  logic        HasExp;
  logic [31:0] EPC;
  logic [31:0] Cp0RData;

  always #5 clk = ~clk;

  cp0_exc_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Irq       (Irq),
    .PresentPC (PresentPC),
    .IsEret    (IsEret),
    .Mtc0      (Mtc0),
    .Cp0Addr   (Cp0Addr),
    .Cp0WData  (Cp0WData),
    .Syscall   (Syscall),
    .RiExc     (RiExc),
    .OvExc     (OvExc),
    .HasExp    (HasExp),
    .EPC       (EPC),
    .Cp0RData  (Cp0RData)
  );

  // kind: 0 = HasExp, 1 = EPC, 2 = Cp0RData
  typedef struct {
    int          kind;
    string       name;
    logic [31:0] exp;
  } chk_t;

  chk_t sbq[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic exp_has(input logic v, input string n);
    sbq.push_back('{0, n, {31'h0, v}});
  endtask

  task automatic exp_epc(input logic [31:0] v, input string n);
    sbq.push_back('{1, n, v});
  endtask

  task automatic exp_rd(input logic [31:0] v, input string n);
    sbq.push_back('{2, n, v});
  endtask

  // Commit the current cycle at the rising edge, then clear per-instruction strobes.
  task automatic step();
    @(posedge clk);
    #1;
    Mtc0 = 1'b0;
    IsEret = 1'b0;
    Syscall = 1'b0;
    RiExc = 1'b0;
    OvExc = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    Mtc0 = 1'b1;
    Cp0Addr = a;
    Cp0WData = d;
  endtask

  // Monitor: compare every expectation queued for this cycle.
  initial begin
    chk_t c;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0) begin
        c = sbq.pop_front();
        case (c.kind)
          0: act = {31'h0, HasExp};
          1: act = EPC;
          default: act = Cp0RData;
        endcase
        vectors++;
        if (act !== c.exp) begin
          miscompares++;
          $display("FAIL %s: got %h, expected %h", c.name, act, c.exp);
        end
      end
    end
  end

  // Driver
  initial begin
    rst_n = 1'b0;
    Irq = 6'h3F;
    PresentPC = 32'h0040_0000;
    IsEret = 1'b0;
    Mtc0 = 1'b0;
    Cp0Addr = 5'd0;
    Cp0WData = 32'h0;
    Syscall = 1'b0;
    RiExc = 1'b0;
    OvExc = 1'b0;
    repeat (3) step();

    // Reset state
    Cp0Addr = 5'd13; exp_rd(32'h0, "rst_cause"); exp_has(1'b0, "rst_hasexp_hold"); step();
    rst_n = 1'b1;
    Cp0Addr = 5'd12; exp_rd(32'h0, "rst_status"); exp_has(1'b0, "rst_hasexp"); exp_epc(32'h0, "rst_epc"); step();
    Irq = 6'h00;
    Cp0Addr = 5'd13; exp_rd(32'h0000_FC00, "irq_sample"); step();

    // Interrupt entry
    mtc0(5'd12, 32'h0000_0401); exp_has(1'b0, "ie_off"); step();
    Irq = 6'h01; PresentPC = 32'h0040_0010;
    Cp0Addr = 5'd12; exp_rd(32'h0000_0401, "status_wr"); exp_has(1'b0, "irq_latency"); step();
    exp_has(1'b1, "irq_taken"); step();
    exp_epc(32'h0040_0010, "int_epc"); Cp0Addr = 5'd12; exp_rd(32'h0000_0403, "int_exl");
    exp_has(1'b0, "exl_masks_irq"); step();
    Cp0Addr = 5'd13; exp_rd(32'h0000_0400, "int_cause"); exp_has(1'b0, "exl_masks_irq2"); Irq = 6'h00; step();
    IsEret = 1'b1; exp_has(1'b0, "eret_quiet"); step();

    // Priority and nesting
    Cp0Addr = 5'd12; exp_rd(32'h0000_0401, "eret_exl_clr");
    RiExc = 1'b1; Syscall = 1'b1; PresentPC = 32'h0040_0020; exp_has(1'b1, "ri_sys_hasexp"); step();
    Cp0Addr = 5'd13; exp_rd(32'h0000_0028, "ri_code"); exp_epc(32'h0040_0020, "ri_epc");
    OvExc = 1'b1; PresentPC = 32'h8000_0184; exp_has(1'b1, "ov_nested_hasexp"); step();
    Cp0Addr = 5'd13; exp_rd(32'h0000_0030, "ov_code"); exp_epc(32'h0040_0020, "nested_epc"); Irq = 6'h01; step();

    // Return with interrupt still asserted
    Cp0Addr = 5'd12; exp_rd(32'h0000_0403, "nested_exl"); IsEret = 1'b1;
    exp_has(1'b0, "eret_int_masked"); step();
    Cp0Addr = 5'd12; exp_rd(32'h0000_0401, "eret_exl0"); PresentPC = 32'h0040_0030;
    exp_has(1'b1, "int_after_eret"); step();
    exp_epc(32'h0040_0030, "int2_epc"); Cp0Addr = 5'd13; exp_rd(32'h0000_0400, "int2_cause"); Irq = 6'h00; step();

    // Write suppression
    mtc0(5'd12, 32'h0); Syscall = 1'b1; exp_has(1'b1, "sys_hasexp"); step();
    Cp0Addr = 5'd12; exp_rd(32'h0000_0403, "mtc0_dropped"); step();
    Cp0Addr = 5'd13; exp_rd(32'h0000_0020, "sys_code"); step();

    // mtc0 to EPC, then software interrupt enabled by mtc0
    mtc0(5'd14, 32'hBFC0_0000); exp_has(1'b0, "epc_wr_ok"); step();
    exp_epc(32'hBFC0_0000, "mtc0_epc"); mtc0(5'd13, 32'h0000_0100); step();
    mtc0(5'd12, 32'h0000_0100); exp_has(1'b0, "sw_ip_no_ie"); step();
    mtc0(5'd12, 32'h0000_0101); exp_rd(32'h0000_0100, "im0_only"); exp_has(1'b0, "ie_pre"); step();
    PresentPC = 32'h0040_0100; exp_has(1'b1, "sw_int_taken"); step();
    exp_epc(32'h0040_0100, "sw_epc"); Cp0Addr = 5'd13; exp_rd(32'h0000_0100, "sw_cause"); step();
    Cp0Addr = 5'd15; exp_rd(32'h0000_0100, "prid"); step();
    Cp0Addr = 5'd3; exp_rd(32'h0, "unmapped"); step();

`ifdef CP0_TIMER_EN
    mtc0(5'd13, 32'h0); exp_has(1'b0, "tmr_clr_sw"); step();
    mtc0(5'd12, 32'h0000_8001); step();
    mtc0(5'd11, 32'd5); exp_has(1'b0, "tmr_idle"); step();
    mtc0(5'd9, 32'd0); step();
    Cp0Addr = 5'd11; exp_rd(32'd5, "compare_rd"); exp_has(1'b0, "tmr_c0"); step();
    Cp0Addr = 5'd9; exp_rd(32'd1, "count_rd"); exp_has(1'b0, "tmr_c1"); step();
    for (int i = 0; i < 3; i++) begin
      exp_has(1'b0, "tmr_wait"); step();
    end
    exp_has(1'b1, "timer_int"); step();
    Cp0Addr = 5'd13; exp_rd(32'h0000_8000, "timer_cause"); step();
    mtc0(5'd11, 32'd100); step();
    Cp0Addr = 5'd13; exp_rd(32'h0, "timer_clr"); IsEret = 1'b1; step();
    exp_has(1'b0, "timer_quiet"); step();
`else
    mtc0(5'd9, 32'h0000_1234); step();
    Cp0Addr = 5'd9; exp_rd(32'h0, "count_off"); step();
    mtc0(5'd11, 32'h0000_0003); step();
    Cp0Addr = 5'd11; exp_rd(32'h0, "compare_off"); step();
`endif

    step();
    step();
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
